// File: rtl/meta_info_pkg.sv
// rtl/meta_info_pkg.sv - shared widths, FSM states and constants for the meta-info reader
package meta_info_pkg;

    localparam int PROJ_W = 6;
    localparam int CHR_W  = 6;
    localparam int CHAR_W = 8;

    localparam logic [PROJ_W-1:0] PROJ_LAST = '1;
    localparam logic [CHAR_W-1:0] NUL_CHAR  = 8'h00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        DECIDE  = 3'd2,
        EMIT    = 3'd3,
        END_STR = 3'd4,
        NEXT    = 3'd5
    } state_t;

endpackage

// File: rtl/meta_string_reader.sv
// rtl/meta_string_reader.sv - walks the meta-info index bus and streams NUL-terminated strings
module meta_string_reader
    import meta_info_pkg::*;
#(
    parameter int                SETTLE_CYCLES = 8,
    parameter int                MAX_LEN       = 63,
    parameter bit                APPEND_EOL    = 1'b1,
    parameter logic [CHAR_W-1:0] EOL_CHAR      = 8'h0A
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      scan_all,
    input  logic [PROJ_W-1:0]         proj_sel,
    output logic [PROJ_W+CHR_W-1:0]   idx_out,
    input  logic [CHAR_W-1:0]         chr_in,
    output logic [CHAR_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CHR_W-1:0] CHR_LAST = CHR_W'(MAX_LEN - 1);

    state_t              state_q, state_d;
    logic [PROJ_W-1:0]   proj_q, proj_d;
    logic [CHR_W-1:0]    chr_q, chr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                scan_q, scan_d;
    logic [CHAR_W-1:0]   byte_q, byte_d;
    logic [CHAR_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                done_q, done_d;

    // Next-state and datapath updates; idx only moves when (re)entering SETTLE
    always_comb begin
        state_d = state_q;
        proj_d  = proj_q;
        chr_d   = chr_q;
        cnt_d   = cnt_q;
        scan_d  = scan_q;
        byte_d  = byte_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    scan_d  = scan_all;
                    proj_d  = scan_all ? '0 : proj_sel;
                    chr_d   = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    byte_d  = chr_in;
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DECIDE: begin
                if (byte_q != NUL_CHAR) begin
                    data_d  = byte_q;
                    valid_d = 1'b1;
                    last_d  = (chr_q == CHR_LAST) && !APPEND_EOL;
                    state_d = EMIT;
                end else begin
                    // EOL is staged on entry so END_STR presents it immediately
                    if (APPEND_EOL) begin
                        data_d  = EOL_CHAR;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                    end
                    state_d = END_STR;
                end
            end
            EMIT: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (chr_q == CHR_LAST) begin
                        if (APPEND_EOL) begin
                            data_d  = EOL_CHAR;
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                        end
                        state_d = END_STR;
                    end else begin
                        chr_d   = chr_q + CHR_W'(1);
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end
                end
            end
            END_STR: begin
                if (!APPEND_EOL) begin
                    state_d = NEXT;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (scan_q && (proj_q != PROJ_LAST)) begin
                    proj_d  = proj_q + PROJ_W'(1);
                    chr_d   = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation without a done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            proj_q  <= '0;
            chr_q   <= '0;
            cnt_q   <= '0;
            scan_q  <= 1'b0;
            byte_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            proj_q  <= proj_d;
            chr_q   <= chr_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign idx_out   = {proj_q, chr_q};
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_meta_string_reader.sv
// tb/tb_meta_string_reader.sv - directed self-checking bench for meta_string_reader
module tb_meta_string_reader;
    import meta_info_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        scan_all = 1'b0;
    logic [5:0]  proj_sel = '0;
    logic        out_ready = 1'b1;
    logic [11:0] idx_out, idx_out2;
    logic [7:0]  chr_in, chr_in2, out_data, out_data2;
    logic        out_valid, out_last, busy, done;
    logic        out_valid2, out_last2, busy2, done2;
    int          rom_mode = 0;

    always #5 clock = ~clock;

    function automatic logic [7:0] hexc(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + 8'(v)) : (8'h41 + 8'(v) - 8'd10);
    endfunction

    function automatic logic [7:0] rom(input logic [11:0] idx, input int mode);
        logic [5:0] p;
        logic [5:0] c;
        p = idx[11:6];
        c = idx[5:0];
        if (mode == 1) begin
            if (c == 6'd0) return 8'h50;
            if (c == 6'd1) return hexc(p[3:0]);
            return 8'h00;
        end
        case (p)
            6'd5: begin
                if (c == 6'd0) return 8'h41;
                if (c == 6'd1) return 8'h42;
                if (c == 6'd2) return 8'h43;
                return 8'h00;
            end
            6'd9:    return 8'h00;
            6'd2:    return 8'h78;
            default: return (c == 6'd0) ? 8'h5A : 8'h00;
        endcase
    endfunction

    assign chr_in  = rom(idx_out, rom_mode);
    assign chr_in2 = rom(idx_out2, rom_mode);

    meta_string_reader #(.SETTLE_CYCLES(8), .MAX_LEN(63), .APPEND_EOL(1'b1), .EOL_CHAR(8'h0A)) u_dut (
        .clock(clock), .reset(reset), .start(start), .scan_all(scan_all), .proj_sel(proj_sel),
        .idx_out(idx_out), .chr_in(chr_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    meta_string_reader #(.SETTLE_CYCLES(2), .MAX_LEN(63), .APPEND_EOL(1'b0), .EOL_CHAR(8'h0A)) u_dut_noeol (
        .clock(clock), .reset(reset), .start(start2), .scan_all(1'b0), .proj_sel(proj_sel),
        .idx_out(idx_out2), .chr_in(chr_in2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(1'b1), .out_last(out_last2), .busy(busy2), .done(done2)
    );

    // Monitor: record handshakes and protocol properties on the falling edge
    logic [7:0]  q_data[$];
    bit          q_last[$];
    logic [11:0] q_idx[$];
    int          q_time[$];
    int          cyc = 0, done_cnt = 0, busy_err = 0, stall_err = 0;
    int          n2_bytes = 0, n2_last = 0, done2_cnt = 0;
    bit          saw63 = 1'b0, stall_prev = 1'b0;
    logic [7:0]  pd;
    logic        pl;
    logic [11:0] pi;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                q_idx.push_back(idx_out);
                q_time.push_back(cyc);
            end
            if (stall_prev && !(out_valid && out_data == pd && out_last == pl && idx_out == pi))
                stall_err++;
            stall_prev = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            pi = idx_out;
            if (done) begin
                done_cnt++;
                if (busy) busy_err++;
            end
            if (idx_out[5:0] == 6'd63) saw63 = 1'b1;
            if (out_valid2) n2_bytes++;
            if (out_valid2 && out_last2) n2_last++;
            if (done2) done2_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] qb(input int i);
        return (i < q_data.size()) ? q_data[i] : 8'hEE;
    endfunction

    function automatic logic [31:0] q4(input int b);
        return {qb(b), qb(b + 1), qb(b + 2), qb(b + 3)};
    endfunction

    task automatic launch(input bit sa, input logic [5:0] ps);
        start = 1'b1;
        scan_all = sa;
        proj_sel = ps;
        step();
        start = 1'b0;
        scan_all = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit rand_ready,
                             input bit poke, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            start = poke && busy && (i % 97 == 5);
            if (start) proj_sel = 6'd5;
            step();
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int  base, d0, errs, lerr, xcnt;
        bit  ok;
        logic [7:0] e;

        // Reset values
        step();
        step();
        chk("reset_outputs", {20'd0, idx_out, out_data, out_valid, out_last, busy, done}, 32'd0);
        reset = 1'b1;
        step();

        // Proj 5 = "ABC", ready high
        base = q_data.size();
        launch(1'b0, 6'd5);
        wait_done(1, 300, 1'b0, 1'b0, ok);
        chk("a_done_seen", ok, 1);
        chk("a_count", q_data.size() - base, 4);
        chk("a_bytes", q4(base), 32'h4142430A);
        chk("a_lasts", {q_last[base], q_last[base+1], q_last[base+2], q_last[base+3]}, 4'b0001);
        chk("a_idx0", q_idx[base], 12'h140);
        chk("a_idx1", q_idx[base+1], 12'h141);
        chk("a_idx2", q_idx[base+2], 12'h142);
        chk("a_char_latency", q_time[base+1] - q_time[base], 10);
        step();
        chk("a_done_once", done_cnt, 1);
        chk("a_busy_with_done", busy_err, 0);

        // Proj 9 = "" with EOL appended
        base = q_data.size();
        launch(1'b0, 6'd9);
        wait_done(2, 100, 1'b0, 1'b0, ok);
        chk("b_done_seen", ok, 1);
        chk("b_count", q_data.size() - base, 1);
        chk("b_byte_last", {qb(base), 7'd0, q_last[base]}, 16'h0A01);

        // No-EOL instance: empty string emits nothing, "ABC" emits three unflagged bytes
        start2 = 1'b1;
        proj_sel = 6'd9;
        step();
        start2 = 1'b0;
        repeat (20) step();
        chk("b2_done", done2_cnt, 1);
        chk("b2_no_bytes", n2_bytes, 0);
        start2 = 1'b1;
        proj_sel = 6'd5;
        step();
        start2 = 1'b0;
        repeat (40) step();
        chk("b2_abc_done", done2_cnt, 2);
        chk("b2_abc_bytes", n2_bytes, 3);
        chk("b2_abc_nolast", n2_last, 0);

        // Proj 2 = 63 'x' with no NUL inside the bound
        base = q_data.size();
        launch(1'b0, 6'd2);
        wait_done(3, 1000, 1'b0, 1'b0, ok);
        chk("c_done_seen", ok, 1);
        chk("c_count", q_data.size() - base, 64);
        xcnt = 0;
        for (int i = 0; i < 63; i++) if (qb(base + i) == 8'h78 && !q_last[base + i]) xcnt++;
        chk("c_x_count", xcnt, 63);
        chk("c_eol", {qb(base + 63), 7'd0, q_last[base + 63]}, 16'h0A01);
        chk("c_last_chr_idx", q_idx[base + 62], {6'd2, 6'd62});
        chk("c_never_idx63", saw63, 0);

        // "ABC" with random backpressure
        base = q_data.size();
        launch(1'b0, 6'd5);
        wait_done(4, 600, 1'b1, 1'b0, ok);
        chk("d_done_seen", ok, 1);
        chk("d_count", q_data.size() - base, 4);
        chk("d_bytes", q4(base), 32'h4142430A);
        chk("d_stall_stable", stall_err, 0);

        // Scan all 64 projects, with start pulses while busy
        rom_mode = 1;
        base = q_data.size();
        launch(1'b1, 6'd17);
        wait_done(5, 5000, 1'b0, 1'b1, ok);
        chk("e_done_seen", ok, 1);
        chk("e_count", q_data.size() - base, 192);
        errs = 0;
        lerr = 0;
        for (int p = 0; p < 64; p++) begin
            for (int k = 0; k < 3; k++) begin
                e = (k == 0) ? 8'h50 : (k == 1) ? hexc(4'(p)) : 8'h0A;
                if (qb(base + 3 * p + k) !== e) errs++;
                if ((base + 3 * p + k) < q_last.size() && q_last[base + 3 * p + k] != (k == 2)) lerr++;
                if (k == 0 && (base + 3 * p) < q_idx.size() && q_idx[base + 3 * p][11:6] != 6'(p)) errs++;
            end
        end
        chk("e_sequence", errs, 0);
        chk("e_lasts", lerr, 0);
        repeat (40) step();
        chk("e_single_done", done_cnt, 5);
        chk("e_idle_after", busy, 0);
        rom_mode = 0;

        // Reset while a byte is held in EMIT
        out_ready = 1'b0;
        base = q_data.size();
        launch(1'b0, 6'd5);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("f_reached_emit", ok, 1);
        step();
        reset = 1'b0;
        #2;
        chk("f_async_reset", {20'd0, idx_out, out_data, out_valid, out_last, busy, done}, 32'd0);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        chk("f_no_done", done_cnt, 5);
        chk("f_nothing_sent", q_data.size() - base, 0);
        launch(1'b0, 6'd5);
        wait_done(6, 300, 1'b0, 1'b0, ok);
        chk("f_restart_done", ok, 1);
        chk("f_restart_bytes", q4(base), 32'h4142430A);
        chk("f_busy_with_done", busy_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
